// File: rtl/cpu_wb_mul_pkg.sv
// cpu_wb_mul_pkg
//   Shared definitions for the sequential CLA multiplier: the controller state
//   encoding, a constant-foldable ceil(log2) for sizing the iteration counter,
//   and the legality test for the BITS_PER_CYCLE parameter.
package cpu_wb_mul_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } mul_state_e;

  // ceil(log2(n)), never less than 1 so a counter always has at least one bit.
  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return (r < 1) ? 1 : r;
  endfunction

  // Only these retire rates are supported by the adder chain.
  function automatic bit bpc_legal(input int b);
    return (b == 1) || (b == 2) || (b == 4) || (b == 8);
  endfunction

endpackage

// File: rtl/cpu_wb_cla_adder.sv
// cpu_wb_cla_adder
//   Combinational carry-look-ahead adder built from 4-bit look-ahead groups.
//   Inside a group every carry is formed from the group's generate/propagate
//   prefix and the group carry-in; groups are chained by their group G/P.
//   Widths that are not a multiple of 4 are zero-padded internally.
// Ports:
//   a, b       in  DATA_WID  addends
//   carry_in   in  1         carry into bit 0
//   sum        out DATA_WID  a + b + carry_in (low DATA_WID bits)
//   carry_out  out 1         carry out of bit DATA_WID-1
module cpu_wb_cla_adder #(
  parameter int DATA_WID = 32
) (
  input  logic [DATA_WID-1:0] a,
  input  logic [DATA_WID-1:0] b,
  input  logic                carry_in,
  output logic [DATA_WID-1:0] sum,
  output logic                carry_out
);

  localparam int NG = (DATA_WID + 3) / 4;
  localparam int PW = NG * 4;

  logic [PW-1:0] ap, bp, g, p;
  logic [PW:0]   cb;   // carry into each bit; cb[PW] is the final group carry
  logic          gg, gp, gc;

  always_comb begin
    ap = '0;
    bp = '0;
    ap[DATA_WID-1:0] = a;
    bp[DATA_WID-1:0] = b;
    g  = ap & bp;
    p  = ap ^ bp;
    cb = '0;
    gc = carry_in;
    gg = 1'b0;
    gp = 1'b1;
    for (int grp = 0; grp < NG; grp++) begin
      gg = 1'b0;
      gp = 1'b1;
      for (int j = 0; j < 4; j++) begin
        // carry into this bit = prefix-generate | prefix-propagate & group cin
        cb[grp*4 + j] = gg | (gp & gc);
        gg = g[grp*4 + j] | (p[grp*4 + j] & gg);
        gp = gp & p[grp*4 + j];
      end
      gc = gg | (gp & gc);
    end
    cb[PW] = gc;
  end

  assign sum       = p[DATA_WID-1:0] ^ cb[DATA_WID-1:0];
  assign carry_out = cb[DATA_WID];

endmodule

// File: rtl/cpu_wb_seq_cla_multiplier.sv
// cpu_wb_seq_cla_multiplier
//   Iterative shift-add multiplier. Each BUSY cycle retires BITS_PER_CYCLE
//   multiplier bits through a chain of cpu_wb_cla_adder instances. A BUSY
//   cycle beyond the N iterations applies the optional sign correction and
//   registers the product, so latency is always N+1 edges from accept.
//   Optional feature macro: CPU_WB_MUL_SIGNED_EN (two's complement operands
//   when in_signed=1). Without it in_signed is ignored.
// Handshakes: a transfer happens on a rising edge where valid && ready.
//   in_ready is high only in IDLE, out_valid only in DONE; both are registered,
//   so neither depends combinationally on the opposite side's inputs.
// Ports:
//   clk, rst_n       clock, asynchronous active-low reset
//   flush            synchronous abort to IDLE, discards in-flight work
//   in_valid/ready   operand handshake; in_signed, multicand, multiplier
//   out_valid/ready  result handshake; product (full width, held in DONE)
module cpu_wb_seq_cla_multiplier
  import cpu_wb_mul_pkg::*;
#(
  parameter int MULTICAND_WID  = 32,
  parameter int MULTIPLIER_WID = 32,
  parameter int BITS_PER_CYCLE = 1
) (
  input  logic                                    clk,
  input  logic                                    rst_n,
  input  logic                                    flush,
  input  logic                                    in_valid,
  output logic                                    in_ready,
  input  logic                                    in_signed,
  input  logic [MULTICAND_WID-1:0]                multicand,
  input  logic [MULTIPLIER_WID-1:0]               multiplier,
  output logic                                    out_valid,
  input  logic                                    out_ready,
  output logic [MULTICAND_WID+MULTIPLIER_WID-1:0] product
);

  localparam int N        = MULTIPLIER_WID / BITS_PER_CYCLE;
  localparam int CNT_W    = clog2(N + 1);
  localparam int PROD_WID = MULTICAND_WID + MULTIPLIER_WID;

  if (!bpc_legal(BITS_PER_CYCLE)) begin : g_bad_bpc
    $error("BITS_PER_CYCLE must be 1, 2, 4 or 8");
  end
  if ((MULTIPLIER_WID % BITS_PER_CYCLE) != 0) begin : g_bad_wid
    $error("MULTIPLIER_WID must be a multiple of BITS_PER_CYCLE");
  end

  mul_state_e                state_q;
  logic [CNT_W-1:0]          cnt_q;
  logic [MULTICAND_WID-1:0]  mc_q;
  logic [MULTICAND_WID-1:0]  acc_q;
  logic [MULTIPLIER_WID-1:0] mult_q;
  logic                      sign_q;
  logic                      in_ready_q;
  logic                      out_valid_q;
  logic [PROD_WID-1:0]       product_q;

  // Operand conditioning at accept time.
  logic [MULTICAND_WID-1:0]  mc_mag;
  logic [MULTIPLIER_WID-1:0] mp_mag;
  logic                      sign_in;

`ifdef CPU_WB_MUL_SIGNED_EN
  logic neg_mc, neg_mp;
  always_comb begin
    neg_mc  = in_signed & multicand[MULTICAND_WID-1];
    neg_mp  = in_signed & multiplier[MULTIPLIER_WID-1];
    // The most-negative value negates to itself, which read as unsigned is
    // exactly its magnitude, so no extra bit is needed.
    mc_mag  = neg_mc ? -multicand : multicand;
    mp_mag  = neg_mp ? -multiplier : multiplier;
    sign_in = neg_mc ^ neg_mp;
  end
`else
  logic unused_in_signed;
  assign unused_in_signed = in_signed;
  always_comb begin
    mc_mag  = multicand;
    mp_mag  = multiplier;
    sign_in = 1'b0;
  end
`endif

  // Adder chain: each stage adds the multiplicand when the current multiplier
  // LSB is set, then shifts {carry, sum, mult} right by one. The carry-out
  // becomes the accumulator MSB after the shift.
  for (genvar k = 0; k < BITS_PER_CYCLE; k++) begin : g_step
    logic [MULTICAND_WID-1:0]  acc_in, acc_out, addend, sum_k;
    logic [MULTIPLIER_WID-1:0] mult_in, mult_out;
    logic                      cout_k;

    if (k == 0) begin : g_first
      assign acc_in  = acc_q;
      assign mult_in = mult_q;
    end else begin : g_next
      assign acc_in  = g_step[k-1].acc_out;
      assign mult_in = g_step[k-1].mult_out;
    end

    assign addend = mult_in[0] ? mc_q : '0;

    cpu_wb_cla_adder #(
      .DATA_WID (MULTICAND_WID)
    ) u_cla (
      .a         (acc_in),
      .b         (addend),
      .carry_in  (1'b0),
      .sum       (sum_k),
      .carry_out (cout_k)
    );

    assign acc_out  = {cout_k, sum_k[MULTICAND_WID-1:1]};
    assign mult_out = {sum_k[0], mult_in[MULTIPLIER_WID-1:1]};
  end

  logic [PROD_WID-1:0] raw_prod;
  assign raw_prod = {acc_q, mult_q};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      mc_q        <= '0;
      acc_q       <= '0;
      mult_q      <= '0;
      sign_q      <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      product_q   <= '0;
    end else if (flush) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            mc_q       <= mc_mag;
            mult_q     <= mp_mag;
            acc_q      <= '0;
            sign_q     <= sign_in;
            cnt_q      <= '0;
            in_ready_q <= 1'b0;
            state_q    <= BUSY;
          end
        end
        BUSY: begin
          if (cnt_q == CNT_W'(N)) begin
            // All N iterations done: apply sign and publish.
            product_q   <= sign_q ? -raw_prod : raw_prod;
            out_valid_q <= 1'b1;
            state_q     <= DONE;
          end else begin
            acc_q  <= g_step[BITS_PER_CYCLE-1].acc_out;
            mult_q <= g_step[BITS_PER_CYCLE-1].mult_out;
            cnt_q  <= cnt_q + CNT_W'(1);
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= IDLE;
          end
        end
        default: begin
          state_q     <= IDLE;
          in_ready_q  <= 1'b1;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign product   = product_q;

endmodule

// File: tb/tb_cpu_wb_seq_cla_multiplier.sv
// tb_cpu_wb_seq_cla_multiplier
//   Two instances: index 0 retires 1 bit/cycle (N=32), index 1 retires
//   4 bits/cycle (N=8). Expected products are queued at accept and popped when
//   the result handshake completes.
module tb_cpu_wb_seq_cla_multiplier;

`ifdef CPU_WB_MUL_SIGNED_EN
  localparam bit SIGNED_EN = 1'b1;
`else
  localparam bit SIGNED_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush     [2];
  logic        in_valid  [2];
  logic        in_signed [2];
  logic        out_ready [2];
  logic [31:0] mc        [2];
  logic [31:0] mp        [2];
  logic        in_ready  [2];
  logic        out_valid [2];
  logic [63:0] product   [2];

  logic [63:0] exp_q0[$];
  logic [63:0] exp_q1[$];

  int n_vec = 0;
  int n_err = 0;

  cpu_wb_seq_cla_multiplier #(
    .MULTICAND_WID(32), .MULTIPLIER_WID(32), .BITS_PER_CYCLE(1)
  ) u_dut1 (
    .clk(clk), .rst_n(rst_n), .flush(flush[0]),
    .in_valid(in_valid[0]), .in_ready(in_ready[0]), .in_signed(in_signed[0]),
    .multicand(mc[0]), .multiplier(mp[0]),
    .out_valid(out_valid[0]), .out_ready(out_ready[0]), .product(product[0])
  );

  cpu_wb_seq_cla_multiplier #(
    .MULTICAND_WID(32), .MULTIPLIER_WID(32), .BITS_PER_CYCLE(4)
  ) u_dut4 (
    .clk(clk), .rst_n(rst_n), .flush(flush[1]),
    .in_valid(in_valid[1]), .in_ready(in_ready[1]), .in_signed(in_signed[1]),
    .multicand(mc[1]), .multiplier(mp[1]),
    .out_valid(out_valid[1]), .out_ready(out_ready[1]), .product(product[1])
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference product: sign-extend or zero-extend, then a plain 64-bit multiply.
  function automatic logic [63:0] model(input logic [31:0] a, input logic [31:0] b,
                                        input logic s);
    logic [63:0] ea, eb;
    if (s && SIGNED_EN) begin
      ea = {{32{a[31]}}, a};
      eb = {{32{b[31]}}, b};
    end else begin
      ea = {32'd0, a};
      eb = {32'd0, b};
    end
    return ea * eb;
  endfunction

  // ---------------- drivers ----------------
  task automatic start_op(input int d, input logic [31:0] a, input logic [31:0] b,
                          input logic s, input bit track, input logic [63:0] exp);
    int w;
    w = 0;
    @(negedge clk);
    while (!in_ready[d] && w < 100) begin
      @(negedge clk);
      w++;
    end
    check("accept_ready", 64'(in_ready[d]), 64'd1);
    mc[d] = a;
    mp[d] = b;
    in_signed[d] = s;
    in_valid[d] = 1'b1;
    if (track) begin
      if (d == 0) exp_q0.push_back(exp);
      else        exp_q1.push_back(exp);
    end
    @(posedge clk);
    #1;
    in_valid[d] = 1'b0;
    check("busy_in_ready", 64'(in_ready[d]), 64'd0);
  endtask

  // Counts edges from the accept edge until out_valid is seen.
  task automatic wait_valid(input int d, input int exp_lat);
    int edges;
    edges = 0;
    while (!out_valid[d] && edges < 200) begin
      @(posedge clk);
      #1;
      edges++;
    end
    check("latency", 64'(edges), 64'(exp_lat));
  endtask

  task automatic take_result(input int d, input int hold);
    logic [63:0] exp, held;
    int depth;
    held = product[d];
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      out_ready[d] = 1'b0;
      check("bp_valid", 64'(out_valid[d]), 64'd1);
      check("bp_product", product[d], held);
      check("bp_in_ready", 64'(in_ready[d]), 64'd0);
    end
    @(negedge clk);
    out_ready[d] = 1'b1;
    depth = (d == 0) ? exp_q0.size() : exp_q1.size();
    check("sb_depth", 64'(depth), 64'd1);
    if (depth > 0) begin
      exp = (d == 0) ? exp_q0.pop_front() : exp_q1.pop_front();
      check("product", product[d], exp);
    end
    @(posedge clk);
    #1;
    out_ready[d] = 1'b0;
    check("post_valid", 64'(out_valid[d]), 64'd0);
    check("post_in_ready", 64'(in_ready[d]), 64'd1);
  endtask

  task automatic run_op(input int d, input logic [31:0] a, input logic [31:0] b,
                        input logic s, input logic [63:0] exp, input int hold);
    start_op(d, a, b, s, 1'b1, exp);
    wait_valid(d, (d == 0) ? 33 : 9);
    take_result(d, hold);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    logic [31:0] ra, rb;
    logic        rs;
    bit          saw_valid, captured;

    for (int d = 0; d < 2; d++) begin
      flush[d] = 1'b0; in_valid[d] = 1'b0; in_signed[d] = 1'b0;
      out_ready[d] = 1'b0; mc[d] = '0; mp[d] = '0;
    end
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      check("rst_in_ready", 64'(in_ready[d]), 64'd1);
      check("rst_out_valid", 64'(out_valid[d]), 64'd0);
      check("rst_product", product[d], 64'd0);
    end

    // Directed vectors
    run_op(0, 32'd3, 32'd5, 1'b0, 64'h0000_0000_0000_000F, 0);
    run_op(1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 64'hFFFF_FFFE_0000_0001, 10);
    run_op(1, 32'd0, 32'd0, 1'b0, 64'd0, 0);

    // Signed vs unsigned interpretation of the same operands
    run_op(1, 32'hFFFF_FFFD, 32'd7, 1'b1,
           SIGNED_EN ? 64'hFFFF_FFFF_FFFF_FFEB : 64'h0000_0006_FFFF_FFEB, 0);
    run_op(1, 32'h8000_0000, 32'h8000_0000, 1'b1, 64'h4000_0000_0000_0000, 0);
    run_op(1, 32'hFFFF_FFFD, 32'd7, 1'b0, 64'h0000_0006_FFFF_FFEB, 0);
    run_op(1, 32'h8000_0000, 32'h8000_0000, 1'b0, 64'h4000_0000_0000_0000, 0);
    run_op(0, 32'hFFFF_FFFD, 32'd7, 1'b1, model(32'hFFFF_FFFD, 32'd7, 1'b1), 0);

    // Flush in the 5th BUSY cycle with a competing in_valid
    start_op(0, 32'h0000_1234, 32'h0000_5678, 1'b0, 1'b0, 64'd0);
    repeat (4) @(posedge clk);
    @(negedge clk);
    flush[0] = 1'b1;
    in_valid[0] = 1'b1;
    mc[0] = 32'd7;
    mp[0] = 32'd9;
    @(posedge clk);
    #1;
    flush[0] = 1'b0;
    in_valid[0] = 1'b0;
    check("flush_in_ready", 64'(in_ready[0]), 64'd1);
    check("flush_out_valid", 64'(out_valid[0]), 64'd0);
    saw_valid = 1'b0;
    captured = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #1;
      if (out_valid[0]) saw_valid = 1'b1;
      if (!in_ready[0]) captured = 1'b1;
    end
    check("flush_no_valid", 64'(saw_valid), 64'd0);
    check("flush_no_capture", 64'(captured), 64'd0);
    run_op(0, 32'd2, 32'd2, 1'b0, 64'd4, 0);

    // Asynchronous reset mid-BUSY
    start_op(0, 32'h0000_DEAD, 32'h0000_BEEF, 1'b0, 1'b0, 64'd0);
    repeat (10) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_in_ready", 64'(in_ready[0]), 64'd1);
    check("arst_out_valid", 64'(out_valid[0]), 64'd0);
    check("arst_product", product[0], 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    run_op(0, 32'd0, 32'hDEAD_BEEF, 1'b0, 64'd0, 0);

    // Random operands on both instances
    for (int i = 0; i < 8; i++) begin
      ra = $urandom();
      rb = $urandom();
      rs = 1'($urandom_range(0, 1));
      run_op(i % 2, ra, rb, rs, model(ra, rb, rs), $urandom_range(0, 3));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
